// File: rtl/reset_req_pkg.sv
// Shared definitions for the reset request block: FSM encoding, write key and
// cause bit positions.
package reset_req_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitRel
    } state_e;

    localparam logic [7:0] ResetKey = 8'hA5;

    localparam int unsigned CauseBtn = 0;
    localparam int unsigned CauseWd  = 1;
    localparam int unsigned CauseSw  = 2;
    localparam int unsigned CausePor = 3;

    localparam logic [3:0] CausePowerUp = 4'b1000;

    function automatic logic key_match(input logic [31:0] data);
        return data[31:24] == ResetKey;
    endfunction

endpackage

// File: rtl/reset_req_deb.sv
// Two-flop synchronizer followed by a debouncer: the output follows the
// synchronized button only after 2^DEB_W consecutive cycles at the new level.
module reset_req_deb #(
    parameter int unsigned DEB_W = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn_db
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_db;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_btn_db <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_btn_db) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                // Counter saturating means 2^DEB_W mismatching cycles in a row.
                r_btn_db <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn_db = r_btn_db;

endmodule

// File: rtl/reset_req.sv
// Reset request generator: merges button, watchdog and software requests into a
// fixed-length rst_req pulse and keeps sticky cause bits readable over IO.
module reset_req
    import reset_req_pkg::*;
#(
    parameter int unsigned DEB_W = 20,
    parameter int unsigned HOLD  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn_in,
    input  logic        i_wd_trig,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rst_req,
    output logic [3:0]  o_cause
);

    localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic             w_btn_db;
    logic             w_wr;
    logic             w_sw_req;
    logic             w_clr;
    logic             w_trig;
    logic [3:0]       w_trig_bits;
    logic             w_unused_wdata;

    state_e           r_state;
    logic [HoldW-1:0] r_hold_cnt;
    logic             r_rst_req;
    // Not touched by i_rst so the cause survives the reset it requested.
    logic [3:0]       r_cause = CausePowerUp;

    reset_req_deb #(
        .DEB_W (DEB_W)
    ) u_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_btn    (i_btn_in),
        .o_btn_db (w_btn_db)
    );

    assign w_wr     = i_stb & i_we;
    assign w_sw_req = w_wr & key_match(i_wdata) & i_wdata[0];
    assign w_clr    = w_wr & key_match(i_wdata) & i_wdata[8];
    assign w_unused_wdata = ^{i_wdata[23:9], i_wdata[7:1]};

    always_comb begin
        w_trig_bits           = '0;
        w_trig_bits[CauseBtn] = w_btn_db;
        w_trig_bits[CauseWd]  = i_wd_trig;
        w_trig_bits[CauseSw]  = w_sw_req;
        w_trig                = |w_trig_bits;
    end

    // Clear first, then set, so a combined clear+request leaves only the new cause.
    always_ff @(posedge i_clk) begin
        r_cause <= (w_clr ? 4'b0000 : r_cause) | w_trig_bits;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_hold_cnt <= '0;
            r_rst_req  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_trig) begin
                        r_state    <= StHold;
                        r_hold_cnt <= HoldW'(HOLD - 1);
                        r_rst_req  <= 1'b1;
                    end
                end
                StHold: begin
                    if (r_hold_cnt == '0) begin
                        r_state   <= StWaitRel;
                        r_rst_req <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                StWaitRel: begin
                    if (!w_btn_db) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_rst_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst_req = r_rst_req;
    assign o_cause   = r_cause;
    assign o_rdata   = {28'b0, r_cause};

endmodule

// File: tb/tb_reset_req.sv
// Self-checking bench for reset_req: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_reset_req;

    localparam int DEB_W = 4;
    localparam int HOLD  = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_btn_in = 1'b0;
    logic        i_wd_trig = 1'b0;
    logic        i_stb = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_wdata = 32'h0;
    logic [31:0] o_rdata;
    logic        o_rst_req;
    logic [3:0]  o_cause;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    reset_req #(
        .DEB_W (DEB_W),
        .HOLD  (HOLD)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_btn_in  (i_btn_in),
        .i_wd_trig (i_wd_trig),
        .i_stb     (i_stb),
        .i_we      (i_we),
        .i_wdata   (i_wdata),
        .o_rdata   (o_rdata),
        .o_rst_req (o_rst_req),
        .o_cause   (o_cause)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pulse as a remaining-cycle count, button as a run length.
    logic [3:0] m_cause = 4'b1000;
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0;
    int         m_run = 0;
    int         m_left = 0;
    bit         m_wait = 1'b0;

    always @(posedge i_clk) begin
        logic wr, key, t_sw, t_wd, t_btn, clr;
        wr    = i_stb && i_we;
        key   = (i_wdata[31:24] == 8'hA5);
        t_sw  = wr && key && i_wdata[0];
        clr   = wr && key && i_wdata[8];
        t_wd  = i_wd_trig;
        t_btn = m_db;
        m_cause = (clr ? 4'h0 : m_cause) | {1'b0, t_sw, t_wd, t_btn};
        if (i_rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_left = 0; m_wait = 0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_wait = 1;
            end else if (m_wait) begin
                if (!m_db) m_wait = 0;
            end else if (t_btn || t_wd || t_sw) begin
                m_left = HOLD;
            end
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == (1 << DEB_W)) begin
                    m_db  = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = i_btn_in;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("model rst_req", {31'b0, o_rst_req}, {31'b0, (m_left > 0)});
            check("model cause", {28'b0, o_cause}, {28'b0, m_cause});
            check("model rdata", o_rdata, {28'b0, m_cause});
            check("model btn_db", {31'b0, dut.w_btn_db}, {31'b0, m_db});
        end
    end

    // Window runner: clears one-cycle strobes each step and tallies rst_req.
    int g_hi, g_rise;
    bit samp [0:255];
    bit g_prev;

    task automatic run(input int n, input int wd_at, input int rst_at);
        g_hi = 0; g_rise = 0; g_prev = o_rst_req;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_stb = 0; i_we = 0; i_wd_trig = 0; i_rst = 0;
            samp[i] = o_rst_req;
            if (o_rst_req) g_hi++;
            if (o_rst_req && !g_prev) g_rise++;
            g_prev = o_rst_req;
            if (i == wd_at) i_wd_trig = 1;
            if (i == rst_at) i_rst = 1;
        end
    endtask

    task automatic drive_write(input logic [31:0] d);
        i_stb = 1; i_we = 1; i_wdata = d;
    endtask

    initial begin
        int  hi;
        bit  any_db;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 0;
        chk_en = 1;

        check("power-up cause", {28'b0, o_cause}, 32'h8);
        check("power-up rdata", o_rdata, 32'h8);
        check("power-up rst_req", {31'b0, o_rst_req}, 32'h0);

        // Button held 30 cycles: one 16-cycle pulse, none after release.
        i_btn_in = 1;
        run(30, -1, -1);
        hi = g_hi;
        i_btn_in = 0;
        run(60, -1, -1);
        check("btn pulse length", hi + g_hi, 16);
        check("btn cause", {28'b0, o_cause}, 32'h9);
        check("btn db released", {31'b0, dut.w_btn_db}, 32'h0);

        drive_write(32'hA5000100);
        run(1, -1, -1);
        check("clear cause", {28'b0, o_cause}, 32'h0);

        drive_write(32'hA5000001);
        run(30, -1, -1);
        check("sw first cycle", {31'b0, samp[0]}, 32'h1);
        check("sw pulse length", g_hi, 16);
        check("sw rises", g_rise, 1);
        check("sw cause", {28'b0, o_cause}, 32'h4);

        drive_write(32'h5A000001);
        run(20, -1, -1);
        check("bad key no pulse", g_hi, 0);
        check("bad key cause", {28'b0, o_cause}, 32'h4);

        // Watchdog and software in the same cycle.
        drive_write(32'hA5000100);
        run(1, -1, -1);
        drive_write(32'hA5000001);
        i_wd_trig = 1;
        run(30, -1, -1);
        check("wd+sw pulse length", g_hi, 16);
        check("wd+sw rises", g_rise, 1);
        check("wd+sw cause", {28'b0, o_cause}, 32'h6);

        drive_write(32'hA5000101);
        run(30, -1, -1);
        check("clear+set cause", {28'b0, o_cause}, 32'h4);
        check("clear+set pulse", g_hi, 16);

        // Watchdog mid-hold must not extend the pulse.
        drive_write(32'hA5000100);
        run(1, -1, -1);
        drive_write(32'hA5000001);
        run(30, 5, -1);
        check("wd mid-hold length", g_hi, 16);
        check("wd mid-hold rises", g_rise, 1);
        check("wd mid-hold cause", {28'b0, o_cause}, 32'h6);

        // Reset mid-hold aborts the pulse, cause kept.
        drive_write(32'hA5000100);
        run(1, -1, -1);
        drive_write(32'hA5000001);
        run(30, -1, 3);
        check("rst hold cycle3", {31'b0, samp[3]}, 32'h1);
        check("rst aborts next", {31'b0, samp[4]}, 32'h0);
        check("rst abort length", g_hi, 4);
        check("rst keeps cause", {28'b0, o_cause}, 32'h4);

        // Bouncing button never qualifies.
        hi = 0; any_db = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge i_clk);
            if (i % 8 == 0) i_btn_in = ~i_btn_in;
            if (o_rst_req) hi++;
            if (dut.w_btn_db) any_db = 1;
        end
        i_btn_in = 0;
        run(30, -1, -1);
        check("bounce no pulse", hi + g_hi, 0);
        check("bounce db low", {31'b0, any_db}, 32'h0);
        drive_write(32'hA5000100);
        run(1, -1, -1);
        check("bounce then clear", o_rdata, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge i_clk);
            i_rst     = ($urandom_range(299) == 0);
            i_wd_trig = ($urandom_range(59) == 0);
            if ($urandom_range(49) == 0) i_btn_in = ~i_btn_in;
            i_stb = ($urandom_range(9) == 0);
            i_we  = $urandom_range(1);
            case ($urandom_range(4))
                0: i_wdata = 32'hA5000001;
                1: i_wdata = 32'hA5000100;
                2: i_wdata = 32'hA5000101;
                3: i_wdata = 32'h5A000101;
                default: i_wdata = $urandom;
            endcase
        end
        @(negedge i_clk);
        i_rst = 0; i_stb = 0; i_we = 0; i_wd_trig = 0;
        @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_req.md
RESET_REQ -- requirements
Module: reset_req

Interface
REQ-001 Parameter DEB_W, default 20, debounce counter width; the button must be stable for 2^DEB_W clk cycles.
REQ-002 Parameter HOLD, default 16, number of clk cycles rst_req stays high per request.
REQ-003 clk  input  1  system clock; single clock domain for all logic.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_in  input  1  raw reset button, active-high, asynchronous to clk.
REQ-006 wd_trig  input  1  watchdog timeout, one-cycle pulse, synchronous to clk.
REQ-007 stb  input  1  IO register access strobe, one cycle.
REQ-008 we  input  1  write enable, qualified by stb.
REQ-009 wdata  input  32  IO write data.
REQ-010 rdata  output  32  IO read data: {28'b0, cause}.
REQ-011 rst_req  output  1  reset request to the downstream reset stretcher (its rst_in).
REQ-012 cause  output  4  sticky reset-cause bits: [0] button, [1] watchdog, [2] software, [3] power-on.

Function
REQ-013 btn_in passes through a 2-FF synchronizer before any other use.
REQ-014 Debounce: btn_db changes to the synchronized level only after 2^DEB_W consecutive cycles at that level; the counter clears on any mismatch.
REQ-015 Software request: write (stb & we) with wdata[31:24]==8'hA5 and wdata[0]==1; any other key is ignored with no side effects.
REQ-016 Cause clear: write with wdata[31:24]==8'hA5 and wdata[8]==1 clears cause[3:0] in the same edge; key mismatch is ignored.
REQ-017 If one write sets both wdata[0] and wdata[8], the clear applies first and the software bit is then set, so cause==4'b0100.
REQ-018 FSM states: IDLE, HOLD, WAIT_REL.
REQ-019 IDLE: on btn_db==1, wd_trig, or a valid software request, go to HOLD and load the hold counter with HOLD-1.
REQ-020 HOLD: rst_req=1; the counter decrements each cycle; at 0, go to WAIT_REL.
REQ-021 WAIT_REL: rst_req=0; stay until btn_db==0, then go to IDLE; this prevents retriggering while the button is held.
REQ-022 rst_req is registered; it rises exactly 1 cycle after the triggering edge and stays high for exactly HOLD cycles.
REQ-023 Each accepted trigger sets its cause bit on the same edge the FSM leaves IDLE; simultaneous triggers set all corresponding bits.
REQ-024 Triggers arriving in HOLD or WAIT_REL set their cause bits, but do not restart or extend the hold.
REQ-025 Reads (stb & ~we) have zero side effects; rdata is combinational from cause and valid in the stb cycle.

Reset
REQ-026 rst forces: FSM=IDLE, rst_req=0, hold counter=0, synchronizer FFs=0, debounce counter=0, btn_db=0.
REQ-027 rst does not affect cause; cause survives the reset it requested.
REQ-028 cause power-up (configuration) value is 4'b1000; it changes only via REQ-016, REQ-017, REQ-023 or REQ-024.
REQ-029 rst asserted mid-HOLD aborts the hold (rst_req=0 next cycle); the downstream stretcher has already latched the request.
REQ-030 With btn_in held through reset, the debouncer re-qualifies the button and re-requests, keeping the system in reset while the button is held.

Structure
REQ-031 The shared package holds the FSM state encoding, the key constant 8'hA5, and the cause bit indices.
REQ-032 One sub-module, reset_req_deb (synchronizer plus debouncer, parameter DEB_W), is instantiated once.
REQ-033 Target size: 120-250 lines of RTL.

Verification (DEB_W=4, HOLD=16 for sim)
REQ-034 Power-up with no stimulus -> cause==4'b1000, rst_req==0, rdata==32'h8.
REQ-035 btn_in high for 30 cycles -> rst_req high for exactly 16 cycles, cause[0]==1, FSM in WAIT_REL until release, then no second pulse.
REQ-036 Write 32'hA5000001 -> rst_req rises next cycle for 16 cycles, cause[2]==1; write 32'h5A000001 -> no effect.
REQ-037 wd_trig and a valid software write in the same cycle -> single 16-cycle pulse, cause[1]==1 and cause[2]==1.
REQ-038 wd_trig at HOLD cycle 5 -> pulse length still 16 cycles, cause[1] set; rst asserted at HOLD cycle 3 -> rst_req==0 next cycle, cause unchanged.
REQ-039 btn_in toggling every 8 cycles -> no request, btn_db==0; write 32'hA5000100 -> cause==4'b0000.
